// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core's execute stage (master) and muldiv_unit (slave).
interface muldiv_unit_if;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;

   modport master (output Start, Op, A, B, input Busy, Done, Result);
   modport slave  (input Start, Op, A, B, output Busy, Done, Result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply / restoring divide.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow requests bypass CALC.
module muldiv_unit (
   input  logic          clk,
   input  logic          rst_n,
   muldiv_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic [31:0] rem_q, rem_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] result_q, result_d;
   logic        busy_q;
   logic        done_q;
`ifdef MULDIV_EARLY_OUT_EN
   logic        early_q, early_d;
`endif

   logic        accept_s;
   logic        sgn_a_s, sgn_b_s;
   logic [31:0] mag_a_s, mag_b_s;
   logic        special_in_s;
   logic [32:0] sum_s;
   logic [32:0] rem_sh_s, trial_s;
   logic [63:0] pfix_s;
   logic [31:0] quo_s, rmd_s, fix_val_s;

   // Operand capture helpers: signedness per funct3 and magnitudes
   always_comb begin
      accept_s     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.Start;
      sgn_a_s      = ((bus.Op == OP_MULH) || (bus.Op == OP_MULHSU) ||
                      (bus.Op == OP_DIV)  || (bus.Op == OP_REM)) && bus.A[31];
      sgn_b_s      = ((bus.Op == OP_MULH) || (bus.Op == OP_DIV) ||
                      (bus.Op == OP_REM)) && bus.B[31];
      mag_a_s      = sgn_a_s ? (32'd0 - bus.A) : bus.A;
      mag_b_s      = sgn_b_s ? (32'd0 - bus.B) : bus.B;
      special_in_s = bus.Op[2] && ((bus.B == 32'd0) ||
                     (!bus.Op[0] && (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF)));
   end

   // Datapath step and FIX-stage result selection
   always_comb begin
      sum_s    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, dvsr_q} : 33'd0);
      rem_sh_s = {rem_q, prod_q[31]};
      trial_s  = rem_sh_s - {1'b0, dvsr_q};
      pfix_s   = neg_q ? (64'd0 - prod_q) : prod_q;
      quo_s    = neg_q ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
      rmd_s    = rneg_q ? (32'd0 - rem_q) : rem_q;
      if (!op_q[2]) begin
         fix_val_s = (op_q == OP_MUL) ? pfix_s[31:0] : pfix_s[63:32];
      end else if (b_q == 32'd0) begin
         fix_val_s = op_q[1] ? a_q : 32'hFFFF_FFFF;
      end else if (!op_q[0] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
         fix_val_s = op_q[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         fix_val_s = op_q[1] ? rmd_s : quo_s;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      dvsr_d   = dvsr_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
`ifdef MULDIV_EARLY_OUT_EN
      early_d  = early_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               op_d   = bus.Op;
               a_d    = bus.A;
               b_d    = bus.B;
               cnt_d  = 6'd0;
               neg_d  = sgn_a_s ^ sgn_b_s;
               rneg_d = sgn_a_s;
               rem_d  = 32'd0;
               if (bus.Op[2]) begin
                  prod_d = {32'd0, mag_a_s};
                  dvsr_d = mag_b_s;
               end else begin
                  prod_d = {32'd0, mag_b_s};
                  dvsr_d = mag_a_s;
               end
`ifdef MULDIV_EARLY_OUT_EN
               // Special divides hold FIX for two cycles so Done lands two edges after Start
               early_d = special_in_s;
               state_d = special_in_s ? ST_FIX : ST_CALC;
`else
               state_d = ST_CALC;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (op_q[2]) begin
               if (!trial_s[32]) begin
                  rem_d = trial_s[31:0];
               end else begin
                  rem_d = rem_sh_s[31:0];
               end
               prod_d = {prod_q[63:32], prod_q[30:0], ~trial_s[32]};
            end else begin
               prod_d = {sum_s, prod_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIX: begin
`ifdef MULDIV_EARLY_OUT_EN
            if (early_q) begin
               early_d = 1'b0;
               state_d = ST_FIX;
            end else begin
               result_d = fix_val_s;
               state_d  = ST_DONE;
            end
`else
            result_d = fix_val_s;
            state_d  = ST_DONE;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= 3'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         cnt_q    <= 6'd0;
         prod_q   <= 64'd0;
         dvsr_q   <= 32'd0;
         rem_q    <= 32'd0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= 32'd0;
`ifdef MULDIV_EARLY_OUT_EN
         early_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         dvsr_q   <= dvsr_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
`ifdef MULDIV_EARLY_OUT_EN
         early_q  <= early_d;
`endif
      end
   end

   // Status flags registered from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= (state_d == ST_CALC) || (state_d == ST_FIX);
         done_q <= (state_d == ST_DONE);
      end
   end

   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
   assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random ops vs. arithmetic model.
module tb_muldiv_unit;

   logic clk;
   logic rst_n;
   muldiv_unit_if bus ();

   muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub, p;
      logic signed [31:0] sa32, sb32;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'd0, b};
      sa32 = a;
      sb32 = b;
      case (op)
         3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa32 / sb32;
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return sa32 % sb32;
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 2;
`endif
      return 33;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, output logic [31:0] res, output int lat, output int busy_n);
      @(negedge clk);
      bus.Start = 1'b1;
      bus.Op = op;
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.Op = 3'($urandom);
      bus.A = $urandom;
      bus.B = $urandom;
      lat = 0;
      busy_n = 0;
      while (!bus.Done && lat < 100) begin
         if (bus.Busy) busy_n++;
         bus.Start = (lat == poke);
         @(posedge clk);
         #1;
         lat++;
      end
      bus.Start = 1'b0;
      res = bus.Result;
   endtask

   task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int poke);
      logic [31:0] res;
      int lat, busy_n;
      run_op(op, a, b, poke, res, lat, busy_n);
      check({name, " result"}, res, exp);
      check({name, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
      check({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat(op, a, b)));
   endtask

   initial begin
      vec_t tbl [12];
      logic [31:0] res;
      int lat, busy_n, done_seen;
      logic [2:0] rop;
      logic [31:0] ra, rb;

      tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
      tbl[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
      tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
      tbl[8]  = '{3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF};
      tbl[9]  = '{3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678};
      tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

      bus.Start = 1'b0;
      bus.Op = 3'd0;
      bus.A = 32'd0;
      bus.B = 32'd0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {31'd0, bus.Busy}, 32'd0);
      check("reset done", {31'd0, bus.Done}, 32'd0);
      check("reset result", bus.Result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, issued back-to-back from the DONE cycle
      for (int i = 0; i < 12; i++) begin
         check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, -1);
      end

      // Done lasts exactly one cycle and Result holds in IDLE
      @(posedge clk);
      #1;
      check("done one cycle", {31'd0, bus.Done}, 32'd0);
      check("result hold idle", bus.Result, 32'd0);

      // Start pulses during CALC are ignored
      check_op("poke calc", 3'd5, 32'd1000, 32'd3, 32'd333, 5);
      check_op("poke calc2", 3'd0, 32'd12, 32'd11, 32'd132, 20);

      // Reset in the middle of CALC
      check_op("pre-reset mul", 3'd0, 32'd7, 32'd3, 32'd21, -1);
      @(negedge clk);
      bus.Start = 1'b1;
      bus.Op = 3'd5;
      bus.A = 32'd1000;
      bus.B = 32'd10;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midcalc rst busy", {31'd0, bus.Busy}, 32'd0);
      check("midcalc rst done", {31'd0, bus.Done}, 32'd0);
      check("midcalc rst result", bus.Result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.Done || bus.Busy) done_seen++;
      end
      check("no done after rst", 32'(done_seen), 32'd0);
      check_op("post-reset divu", 3'd5, 32'd1000, 32'd10, 32'd100, -1);

      // Randomized operations against the arithmetic model
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(rop, ra, rb, -1, res, lat, busy_n);
         check($sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb), res, ref_model(rop, ra, rb));
         check($sformatf("rand%0d latency", i), 32'(lat), 32'(exp_lat(rop, ra, rb)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit alongside the single-cycle datapath's ALU. It acts as the responder to the core's multi-cycle execute request: it accepts operands and a funct3 opcode on a Start pulse, runs a 32-iteration shift-add multiply or restoring divide, and returns the 32-bit result with a one-cycle Done pulse. The core stalls on Busy.

## Interface
- No parameters; datapath fixed at 32 bits.

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Start  in  1  request strobe; sampled only when accepting (IDLE or DONE state)
- Op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  in  32  rs1 operand (multiplicand / dividend)
- B  in  32  rs2 operand (multiplier / divisor)
- Busy  out  1  high in CALC and FIX states
- Done  out  1  high for exactly one cycle (DONE state); Result valid
- Result  out  32  registered result; held until the next Done

## Operation
- States: IDLE, CALC, FIX, DONE. Reset state is IDLE.
- IDLE/DONE with Start=1:
  - Capture Op, A and B.
  - Take operand magnitudes per signedness: MULH signed×signed, MULHSU signed A × unsigned B, DIV/REM signed.
  - Clear the 6-bit iteration counter and go to CALC.
- DONE with Start=0 goes to IDLE. IDLE with Start=0 stays in IDLE.
- Start while Busy=1 is ignored. Operand or Op changes after capture have no effect.
- CALC, multiply: 64-bit product register, one shift-add per cycle.
- CALC, divide: restoring step per cycle on a 33-bit partial remainder; quotient bits are shifted in.
- CALC lasts 32 cycles, then FIX.
- FIX:
  - Negate the product, quotient or remainder as required. Remainder takes the dividend's sign; quotient is negative when the operand signs differ.
  - Select the output: MUL low 32 bits; MULH, MULHSU and MULHU high 32 bits.
  - Apply divide special cases, then load Result and go to DONE.
- Divide special cases (override the datapath):
  - B=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - DIV with A=0x80000000, B=0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
- All arithmetic is modulo 2^32 on the output. No exceptions are raised.

## Timing
- Reset values: Busy=0, Done=0, Result=0, state IDLE, counter 0.
- rst_n low at any time, including mid-CALC, forces these values immediately. The in-flight operation is discarded and no Done is produced.
- Start sampled high at edge N:
  - Busy high from after edge N until edge N+33.
  - Done and Result valid between edges N+33 and N+34.
- Fixed latency of 33 edges for every Op and operand value, unless MULDIV_EARLY_OUT_EN is defined.
- Back-to-back requests: Start high during the DONE cycle is accepted at that edge. Busy then rises on the same edge that Done falls.
- Result holds its value through IDLE and the next CALC and FIX. It changes only when entering DONE.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - Divide-by-zero and signed-overflow divide requests skip CALC (IDLE/DONE → FIX → DONE).
  - Done is high between edges N+2 and N+3.
  - All other requests keep the 33-edge latency.
- Not defined: every request takes CALC, with fixed 33-edge latency. Special-case values are still applied in FIX.

## Test plan
- MUL A=7, B=0xFFFFFFFD → Result 0xFFFFFFEB. Done one cycle exactly 33 edges after Start; Busy high for the 33 preceding cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Signed divide, A=0xFFFFFFF9 (−7), B=2: DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU 100/7 → 14 and REMU 100/7 → 2.
- Divide special cases:
  - DIV 0x12345678/0 → 0xFFFFFFFF; REMU 0x12345678/0 → 0x12345678.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Latency is 33 edges without the macro and 2 edges with MULDIV_EARLY_OUT_EN.
- Start pulses during CALC with different operands are ignored; the original result is returned. Start during DONE is accepted back-to-back, with no IDLE cycle between.
- rst_n pulsed low at CALC iteration 10 → Busy, Done and Result go to 0 immediately. No Done follows. A new Start after release completes normally.
